// File: rtl/ex_mem_pkg.sv
// Shared defaults and control-bundle type for the EX/MEM pipeline register.
package ex_mem_pkg;

  localparam int DATA_WIDTH_DEF     = 32;
  localparam int REG_ADDR_WIDTH_DEF = 5;

  typedef struct packed {
    logic MemToReg;
    logic RegWrite;
    logic MemRead;
    logic MemWrite;
  } ex_mem_ctrl_t;

endpackage : ex_mem_pkg

// File: rtl/ex_mem_register_pipe_reg_en.sv
// Generic WIDTH-bit pipeline flop with load enable and asynchronous
// active-high clear to zero.
module pipe_reg_en #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  // Load-or-hold selection.
  always_comb begin
    data_d = data_q;
    if (en) begin
      data_d = d;
    end else begin
      data_d = data_q;
    end
  end

  // State flop with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule : pipe_reg_en

// File: rtl/ex_mem_register.sv
// EX/MEM pipeline register: data, destination address and MEM/WB controls.
// Optional EX_MEM_FLUSH_EN adds a flush input that bubbles address/controls.
module ex_mem_register
  import ex_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
`ifdef EX_MEM_FLUSH_EN
  input  logic                      flush,
`endif
  input  logic [DATA_WIDTH-1:0]     alu_result_ex,
  input  logic [DATA_WIDTH-1:0]     write_data_ex,
  input  logic [REG_ADDR_WIDTH-1:0] write_reg_addr_ex,
  input  logic                      ctrl_MemToReg_ex,
  input  logic                      ctrl_RegWrite_ex,
  input  logic                      ctrl_MemRead_ex,
  input  logic                      ctrl_MemWrite_ex,
  output logic [DATA_WIDTH-1:0]     alu_result_mem,
  output logic [DATA_WIDTH-1:0]     write_data_mem,
  output logic [REG_ADDR_WIDTH-1:0] write_reg_addr_mem,
  output logic                      ctrl_MemToReg_mem,
  output logic                      ctrl_RegWrite_mem,
  output logic                      ctrl_MemRead_mem,
  output logic                      ctrl_MemWrite_mem
);

  ex_mem_ctrl_t              ctrl_ex_s;
  ex_mem_ctrl_t              ctrl_d_s;
  ex_mem_ctrl_t              ctrl_mem_s;
  logic [REG_ADDR_WIDTH-1:0] addr_d_s;
  logic                      bubble_en_s;

  // Address and controls share one enable; a flush forces a zero load.
  always_comb begin
    ctrl_ex_s.MemToReg = ctrl_MemToReg_ex;
    ctrl_ex_s.RegWrite = ctrl_RegWrite_ex;
    ctrl_ex_s.MemRead  = ctrl_MemRead_ex;
    ctrl_ex_s.MemWrite = ctrl_MemWrite_ex;
    ctrl_d_s           = ctrl_ex_s;
    addr_d_s           = write_reg_addr_ex;
    bubble_en_s        = en;
`ifdef EX_MEM_FLUSH_EN
    if (flush) begin
      ctrl_d_s    = '0;
      addr_d_s    = '0;
      bubble_en_s = 1'b1;
    end else begin
      ctrl_d_s    = ctrl_ex_s;
      addr_d_s    = write_reg_addr_ex;
      bubble_en_s = en;
    end
`endif
  end

  pipe_reg_en #(.WIDTH(2 * DATA_WIDTH)) u_data_reg (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .d   ({alu_result_ex, write_data_ex}),
    .q   ({alu_result_mem, write_data_mem})
  );

  pipe_reg_en #(.WIDTH(REG_ADDR_WIDTH)) u_addr_reg (
    .clk (clk),
    .rst (rst),
    .en  (bubble_en_s),
    .d   (addr_d_s),
    .q   (write_reg_addr_mem)
  );

  pipe_reg_en #(.WIDTH($bits(ex_mem_ctrl_t))) u_ctrl_reg (
    .clk (clk),
    .rst (rst),
    .en  (bubble_en_s),
    .d   (ctrl_d_s),
    .q   (ctrl_mem_s)
  );

  assign ctrl_MemToReg_mem = ctrl_mem_s.MemToReg;
  assign ctrl_RegWrite_mem = ctrl_mem_s.RegWrite;
  assign ctrl_MemRead_mem  = ctrl_mem_s.MemRead;
  assign ctrl_MemWrite_mem = ctrl_mem_s.MemWrite;

endmodule : ex_mem_register

// File: tb/tb_ex_mem_register.sv
// Self-checking bench for ex_mem_register: directed plan plus random stimulus
// compared against a simple expected-state model.
module tb_ex_mem_register;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
`ifdef EX_MEM_FLUSH_EN
  logic        flush;
`endif
  logic [31:0] alu_result_ex;
  logic [31:0] write_data_ex;
  logic [4:0]  write_reg_addr_ex;
  logic [3:0]  ctrl_ex;  // {MemToReg, RegWrite, MemRead, MemWrite}
  logic [31:0] alu_result_mem;
  logic [31:0] write_data_mem;
  logic [4:0]  write_reg_addr_mem;
  logic        ctrl_MemToReg_mem;
  logic        ctrl_RegWrite_mem;
  logic        ctrl_MemRead_mem;
  logic        ctrl_MemWrite_mem;

  int checks = 0;
  int errors = 0;

  // Expected pipeline-register contents.
  logic [31:0] exp_alu;
  logic [31:0] exp_wd;
  logic [4:0]  exp_addr;
  logic [3:0]  exp_ctrl;

  always #5 clk = ~clk;

  ex_mem_register dut (
    .clk                (clk),
    .rst                (rst),
    .en                 (en),
`ifdef EX_MEM_FLUSH_EN
    .flush              (flush),
`endif
    .alu_result_ex      (alu_result_ex),
    .write_data_ex      (write_data_ex),
    .write_reg_addr_ex  (write_reg_addr_ex),
    .ctrl_MemToReg_ex   (ctrl_ex[3]),
    .ctrl_RegWrite_ex   (ctrl_ex[2]),
    .ctrl_MemRead_ex    (ctrl_ex[1]),
    .ctrl_MemWrite_ex   (ctrl_ex[0]),
    .alu_result_mem     (alu_result_mem),
    .write_data_mem     (write_data_mem),
    .write_reg_addr_mem (write_reg_addr_mem),
    .ctrl_MemToReg_mem  (ctrl_MemToReg_mem),
    .ctrl_RegWrite_mem  (ctrl_RegWrite_mem),
    .ctrl_MemRead_mem   (ctrl_MemRead_mem),
    .ctrl_MemWrite_mem  (ctrl_MemWrite_mem)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".alu"},  alu_result_mem, exp_alu);
    check({tag, ".wd"},   write_data_mem, exp_wd);
    check({tag, ".addr"}, {27'd0, write_reg_addr_mem}, {27'd0, exp_addr});
    check({tag, ".ctrl"},
          {28'd0, ctrl_MemToReg_mem, ctrl_RegWrite_mem, ctrl_MemRead_mem, ctrl_MemWrite_mem},
          {28'd0, exp_ctrl});
  endtask

  task automatic model_clear();
    exp_alu  = 32'd0;
    exp_wd   = 32'd0;
    exp_addr = 5'd0;
    exp_ctrl = 4'd0;
  endtask

  // One rising edge: update the model from the inputs held across it, then check.
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (en) begin
        exp_alu = alu_result_ex;
        exp_wd  = write_data_ex;
      end
`ifdef EX_MEM_FLUSH_EN
      if (flush) begin
        exp_addr = 5'd0;
        exp_ctrl = 4'd0;
      end else if (en) begin
        exp_addr = write_reg_addr_ex;
        exp_ctrl = ctrl_ex;
      end
`else
      if (en) begin
        exp_addr = write_reg_addr_ex;
        exp_ctrl = ctrl_ex;
      end
`endif
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    // Reset with all inputs nonzero.
    rst = 1'b1;
    en  = 1'b1;
`ifdef EX_MEM_FLUSH_EN
    flush = 1'b0;
`endif
    alu_result_ex     = 32'h1234_5678;
    write_data_ex     = 32'hCAFE_BABE;
    write_reg_addr_ex = 5'd10;
    ctrl_ex           = 4'b1111;
    tick("reset");

    // Release reset mid-cycle: no capture before the next edge.
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_clear();
    check_all("reset_release");

    tick("capture");
    check("capture.alu_const", alu_result_mem, 32'h1234_5678);
    check("capture.addr_const", {27'd0, write_reg_addr_mem}, 32'd10);

    // Stall: inputs change, outputs hold.
    en                = 1'b0;
    alu_result_ex     = 32'hDEAD_BEEF;
    write_data_ex     = 32'hABCD_1234;
    write_reg_addr_ex = 5'd20;
    ctrl_ex           = 4'b1011;
    tick("stall");
    check("stall.wd_const", write_data_mem, 32'hCAFE_BABE);
    check("stall.regwrite", {31'd0, ctrl_RegWrite_mem}, 32'd1);

    // Asynchronous reset between edges.
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_clear();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back capture with one-cycle lag.
    en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      alu_result_ex = 32'(i);
      tick($sformatf("b2b%0d", i));
      check($sformatf("b2b%0d.lag", i), alu_result_mem, 32'(i));
    end

`ifdef EX_MEM_FLUSH_EN
    flush             = 1'b1;
    alu_result_ex     = 32'h0000_0055;
    write_reg_addr_ex = 5'd7;
    ctrl_ex           = 4'b1111;
    tick("flush");
    check("flush.alu_const", alu_result_mem, 32'h0000_0055);
    check("flush.ctrl_const",
          {28'd0, ctrl_MemToReg_mem, ctrl_RegWrite_mem, ctrl_MemRead_mem, ctrl_MemWrite_mem},
          32'd0);
    flush = 1'b0;
`endif

    // Random traffic with random stalls.
    for (int i = 0; i < 60; i++) begin
      en                = ($urandom_range(3) != 0) ? 1'b1 : 1'b0;
      alu_result_ex     = $urandom;
      write_data_ex     = $urandom;
      write_reg_addr_ex = 5'($urandom_range(31));
      ctrl_ex           = 4'($urandom_range(15));
`ifdef EX_MEM_FLUSH_EN
      flush             = ($urandom_range(7) == 0) ? 1'b1 : 1'b0;
`endif
      tick($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_ex_mem_register
